// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker state, standard polynomial length/tap pairs,
// and the next-bit function common to the pattern generator and the checker.
package prbs_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } prbs_state_e;

  localparam int unsigned PRBS7_LEN  = 7;
  localparam int unsigned PRBS7_TAP  = 6;
  localparam int unsigned PRBS15_LEN = 15;
  localparam int unsigned PRBS15_TAP = 14;
  localparam int unsigned PRBS31_LEN = 31;
  localparam int unsigned PRBS31_TAP = 28;

  // sr[0] holds the newest bit; the next bit is sr[len-1] ^ sr[tap-1].
  function automatic logic prbs_next_bit(input logic [31:0] sr,
                                         input int unsigned len,
                                         input int unsigned tap);
    return 1'(sr >> (len - 1)) ^ 1'(sr >> (tap - 1));
  endfunction

endpackage

// File: rtl/prbs_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module prbs_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_q <= '0;
    end else if (i_inc && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker with lock detection and BER counters.
// Build option PRBS_CHK_INV_EN: invert din before all processing (swapped pair).
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned POLY_LEN = PRBS7_LEN,
  parameter int unsigned TAP_B    = PRBS7_TAP,
  parameter int unsigned LOCK_CNT = 16,
  parameter int unsigned WIN_LEN  = 128,
  parameter int unsigned LOSS_THR = 8,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_flag,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] bit_cnt
);

  localparam int unsigned WIN_W  = $clog2(WIN_LEN + 1);
  localparam int unsigned WERR_W = $clog2(LOSS_THR + 1);

  prbs_state_e         r_state, w_state_nxt;
  logic [POLY_LEN-1:0] r_sr;
  logic [7:0]          r_good_cnt;
  logic [WIN_W-1:0]    r_win_cnt;
  logic [WERR_W-1:0]   r_win_err, w_win_err_nxt;
  logic                r_err_flag;
  logic                w_din, w_pred, w_match, w_mismatch;
  logic                w_lock_hit, w_loss, w_win_end;
  logic                w_bit_inc, w_err_inc;

`ifdef PRBS_CHK_INV_EN
  assign w_din = ~din;
`else
  assign w_din = din;
`endif

  assign w_pred        = prbs_next_bit(32'(r_sr), POLY_LEN, TAP_B);
  assign w_mismatch    = (w_din != w_pred);
  assign w_match       = !w_mismatch && (r_sr != '0);
  assign w_lock_hit    = w_match && (r_good_cnt == 8'(LOCK_CNT - 1));
  assign w_win_err_nxt = r_win_err + WERR_W'(w_mismatch);
  assign w_loss        = (w_win_err_nxt == WERR_W'(LOSS_THR));
  assign w_win_end     = (r_win_cnt == WIN_W'(WIN_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= SEARCH;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (din_valid) begin
      unique case (r_state)
        SEARCH:  if (w_lock_hit) w_state_nxt = LOCKED;
        LOCKED:  if (w_loss)     w_state_nxt = SEARCH;
        default: w_state_nxt = SEARCH;
      endcase
    end
  end

  always_comb begin
    locked = (r_state == LOCKED);
  end

  // In LOCKED the register free-runs on its own prediction so a bad bit never
  // enters it; only the losing bit is shifted in, to start reacquisition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr       <= '0;
      r_good_cnt <= '0;
      r_win_cnt  <= '0;
      r_win_err  <= '0;
      r_err_flag <= 1'b0;
    end else if (!din_valid) begin
      r_err_flag <= 1'b0;
    end else if (r_state == SEARCH) begin
      r_sr       <= {r_sr[POLY_LEN-2:0], w_din};
      r_good_cnt <= (w_match && !w_lock_hit) ? r_good_cnt + 8'd1 : 8'd0;
      r_win_cnt  <= '0;
      r_win_err  <= '0;
      r_err_flag <= 1'b0;
    end else begin
      r_err_flag <= w_mismatch;
      r_good_cnt <= '0;
      if (w_loss) begin
        r_sr      <= {r_sr[POLY_LEN-2:0], w_din};
        r_win_cnt <= '0;
        r_win_err <= '0;
      end else begin
        r_sr <= {r_sr[POLY_LEN-2:0], w_pred};
        if (w_win_end) begin
          r_win_cnt <= '0;
          r_win_err <= '0;
        end else begin
          r_win_cnt <= r_win_cnt + 1'b1;
          r_win_err <= w_win_err_nxt;
        end
      end
    end
  end

  assign err_flag  = r_err_flag;
  assign w_bit_inc = din_valid && (r_state == LOCKED);
  assign w_err_inc = w_bit_inc && w_mismatch;

  prbs_sat_counter #(.W(ERR_W)) u_err_cnt (
    .i_clk (clk),
    .i_rst (rst),
    .i_inc (w_err_inc),
    .i_clr (clr_cnt),
    .o_q   (err_cnt)
  );

  prbs_sat_counter #(.W(ERR_W)) u_bit_cnt (
    .i_clk (clk),
    .i_rst (rst),
    .i_inc (w_bit_inc),
    .i_clr (clr_cnt),
    .o_q   (bit_cnt)
  );

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed PRBS7 scenarios, a behavioural reference
// model checked every cycle, plus literal expectations at key points.
module tb_prbs_checker;

  localparam int POLY_LEN = 7;
  localparam int TAP_B    = 6;
  localparam int LOCK_CNT = 16;
  localparam int WIN_LEN  = 128;
  localparam int LOSS_THR = 8;
  localparam int ERR_W    = 16;
  localparam int CNT_MAX  = (1 << ERR_W) - 1;
`ifdef PRBS_CHK_INV_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din_valid = 1'b0;
  logic din = 1'b0;
  logic clr_cnt = 1'b0;
  logic locked, err_flag;
  logic [ERR_W-1:0] err_cnt, bit_cnt;

  int checks = 0;
  int errors = 0;
  bit stream [4096];
  int idx = 0;

  prbs_checker #(
    .POLY_LEN (POLY_LEN),
    .TAP_B    (TAP_B),
    .LOCK_CNT (LOCK_CNT),
    .WIN_LEN  (WIN_LEN),
    .LOSS_THR (LOSS_THR),
    .ERR_W    (ERR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din_valid (din_valid),
    .din       (din),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_flag  (err_flag),
    .err_cnt   (err_cnt),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: last POLY_LEN received bits as a queue, oldest first.
  bit m_locked, m_flag;
  int m_err, m_bits, m_run, m_since, m_werr;
  bit m_hist[$];

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  always @(posedge clk) begin
    bit d, pred, nz, mis;
    int pos;
    if (rst) begin
      m_locked = 0; m_flag = 0; m_err = 0; m_bits = 0;
      m_run = 0; m_since = 0; m_werr = 0;
      m_hist.delete();
      for (int i = 0; i < POLY_LEN; i++) m_hist.push_back(1'b0);
    end else begin
      if (din_valid) begin
        d = din ^ INV;
        pred = m_hist[0] ^ m_hist[POLY_LEN - TAP_B];
        nz = 0;
        foreach (m_hist[i]) nz |= m_hist[i];
        mis = (d != pred);
        if (!m_locked) begin
          m_flag = 0;
          m_run = (!mis && nz) ? m_run + 1 : 0;
          m_hist.push_back(d);
          if (m_run == LOCK_CNT) begin
            m_locked = 1; m_run = 0; m_since = 0; m_werr = 0;
          end
        end else begin
          m_flag = mis;
          m_bits = sat_inc(m_bits);
          if (mis) m_err = sat_inc(m_err);
          pos = m_since % WIN_LEN;
          m_since++;
          m_werr += int'(mis);
          if (m_werr == LOSS_THR) begin
            m_locked = 0; m_run = 0; m_werr = 0;
            m_hist.push_back(d);
          end else begin
            m_hist.push_back(pred);
            if (pos == WIN_LEN - 1) m_werr = 0;
          end
        end
        void'(m_hist.pop_front());
      end else begin
        m_flag = 0;
      end
      if (clr_cnt) begin
        m_err = 0; m_bits = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_locked",   locked,   m_locked);
    chk("model_err_flag", err_flag, m_flag);
    chk("model_err_cnt",  err_cnt,  m_err);
    chk("model_bit_cnt",  bit_cnt,  m_bits);
  end

  task automatic drive(input bit v, input bit d, input bit c);
    din_valid = v; din = d; clr_cnt = c;
    @(posedge clk);
    #1;
  endtask

  task automatic feed_one(input bit flip, input bit clr);
    drive(1'b1, stream[idx] ^ INV ^ flip, clr);
    idx++;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) feed_one(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idx = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, cyc, vcount;
    // PRBS7 x^7+x^6+1 from seed 7'h7F: b[n] = b[n-7] ^ b[n-6], history all ones.
    for (int n = 0; n < 4096; n++)
      stream[n] = ((n >= 7) ? stream[n-7] : 1'b1) ^ ((n >= 6) ? stream[n-6] : 1'b1);

    // Reset state
    do_reset();
    chk("rst_locked", locked, 0);
    chk("rst_err_flag", err_flag, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_bit_cnt", bit_cnt, 0);

    // Lock: first match is bit 7, 16th consecutive match is bit 22
    feed(22);
    chk("lock_not_yet", locked, 0);
    feed(1);
    chk("lock_at_bit22", locked, 1);
    feed(1000 - 23);
    chk("clean_err_cnt", err_cnt, 0);
    chk("clean_bit_cnt", bit_cnt, 977);

    // Single error at bit 200, no propagation
    do_reset();
    feed(200);
    feed_one(1'b1, 1'b0);
    chk("single_flag", err_flag, 1);
    chk("single_cnt", err_cnt, 1);
    feed(1);
    chk("single_flag_drop", err_flag, 0);
    feed(100);
    chk("single_no_prop", err_cnt, 1);
    chk("single_still_locked", locked, 1);

    // Loss of lock: 8 errors inside one window
    do_reset();
    feed(200);
    for (int k = 0; k < LOSS_THR; k++) begin
      feed_one(1'b1, 1'b0);
      if (k == LOSS_THR - 2) chk("loss_7th_locked", locked, 1);
      if (k < LOSS_THR - 1) feed(3);
    end
    chk("loss_unlocked", locked, 0);
    chk("loss_err_kept", err_cnt, 8);
    cnt = 0;
    while (!locked && cnt < 40) begin
      feed_one(1'b0, 1'b0);
      cnt++;
    end
    chk("relock_within_23", (locked === 1'b1) && (cnt <= 23), 1);
    chk("relock_err_kept", err_cnt, 8);

    // Stuck-low line
    do_reset();
    for (int i = 0; i < 500; i++) drive(1'b1, 1'b0, 1'b0);
    chk("stuck_no_lock", locked, 0);

    // Bubbles every 3rd cycle: lock point in valid bits unchanged
    do_reset();
    cyc = 0; vcount = 0;
    while (!locked && cyc < 200) begin
      if (cyc % 3 == 2) drive(1'b0, 1'b0, 1'b0);
      else begin
        feed_one(1'b0, 1'b0);
        vcount++;
      end
      cyc++;
    end
    chk("gap_lock_point", vcount, 23);
    feed(30);
    feed_one(1'b1, 1'b0);
    feed(5);
    chk("gap_err_one", err_cnt, 1);
    feed_one(1'b1, 1'b1);
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_bit_cnt", bit_cnt, 0);
    chk("clr_flag_kept", err_flag, 1);
    chk("clr_lock_kept", locked, 1);

    // Reset mid-lock with err_cnt = 5
    do_reset();
    feed(50);
    for (int k = 0; k < 5; k++) begin
      feed_one(1'b1, 1'b0);
      feed(5);
    end
    chk("midlock_err5", err_cnt, 5);
    rst = 1'b1;
    feed_one(1'b1, 1'b0);
    chk("midrst_locked", locked, 0);
    chk("midrst_flag", err_flag, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    chk("midrst_bit_cnt", bit_cnt, 0);
    rst = 1'b0;

    // Wrong polarity stream never locks
    do_reset();
    for (int i = 0; i < 300; i++) feed_one(1'b1, 1'b0);
    chk("wrong_pol_no_lock", locked, 0);

    drive(1'b0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
